// File: rtl/rel_compare_unit.sv
// Multi-cycle relational comparator: GT/LT/EQ/NE/GE/LE, signed or unsigned,
// walking CHUNK bits per cycle from the MSB chunk and exiting on first difference.
module rel_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             n,
  output logic             z,
  output logic             illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             c_gt;
  logic             c_lt;
  logic             ill;
  logic             rel;

  // Signed order equals unsigned order once the sign bits are flipped.
  always_comb begin
    ca = a_q[int'(idx)*CHUNK +: CHUNK];
    cb = b_q[int'(idx)*CHUNK +: CHUNK];
    if (sgn_q && idx == TOP) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    c_gt = ca > cb;
    c_lt = ca < cb;
  end

  always_comb begin
    rel = 1'b0;
    unique case (op_q)
      3'b000: rel = gt_q;
      3'b001: rel = lt_q;
      3'b010: rel = eq_q;
      3'b011: rel = !eq_q;
      3'b100: rel = gt_q | eq_q;
      3'b101: rel = lt_q | eq_q;
      default: rel = 1'b0;
    endcase
  end

  assign ill = op_q[2] & op_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 3'b000;
      sgn_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            sgn_q <= is_signed;
            idx   <= TOP;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            state <= CMP;
          end
        end
        CMP: begin
          if (c_gt || c_lt || idx == '0) begin
            gt_q  <= c_gt;
            lt_q  <= c_lt;
            eq_q  <= !(c_gt || c_lt);
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = out_valid && !ill && rel;
  assign illegal   = out_valid && ill;
  assign z         = !result;
  assign n         = 1'b0;

endmodule

// File: tb/tb_rel_compare_unit.sv
// Scoreboard bench for rel_compare_unit: randomized and directed requests
// against an arithmetic reference model, with latency and hold checks.
module tb_rel_compare_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = 3'b000;
  logic             is_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             result;
  logic             n;
  logic             z;
  logic             illegal;

  rel_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op(op),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .n(n),
    .z(z),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic res;
    logic ill;
    int   lat;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   or_mode = 0;
  logic seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma,
                                 input logic [WIDTH-1:0] mb,
                                 input logic [2:0] mop,
                                 input logic ms);
    exp_t e;
    logic gt, lt, eq;
    logic [WIDTH-1:0] d;
    int hi;
    gt = ms ? ($signed(ma) > $signed(mb)) : (ma > mb);
    lt = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
    eq = (ma == mb);
    e.ill = (mop >= 3'd6);
    case (mop)
      3'd0: e.res = gt;
      3'd1: e.res = lt;
      3'd2: e.res = eq;
      3'd3: e.res = !eq;
      3'd4: e.res = gt || eq;
      3'd5: e.res = lt || eq;
      default: e.res = 1'b0;
    endcase
    d = ma ^ mb;
    hi = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) hi = i;
    e.lat = (hi < 0) ? NCHUNK + 1 : NCHUNK - hi / CHUNK + 1;
    e.acc = 0;
    return e;
  endfunction

  // Consumer back-pressure: 0 always ready, 1 random, 2 stalled.
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom % 2);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb[0];
        if (!seen) chk("latency", cyc - e.acc + 1, e.lat);
        seen = 1'b1;
        chk("result", result, e.res);
        chk("z", z, !e.res);
        chk("illegal", illegal, e.ill);
        chk("n", n, 0);
        chk("in_ready_busy", in_ready, 0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic [2:0] iop, input logic is);
    int g;
    exp_t e;
    g = 0;
    a = ia;
    b = ib;
    op = iop;
    is_signed = is;
    in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 300) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got 0 expected 1 (cycle %0d)", cyc);
    end else begin
      e = model(ia, ib, iop, is);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d expected 0 pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_z", z, 1);
    chk("rst_n", n, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk);
    #1;

    or_mode = 0;
    issue(32'd1, 32'd2, 3'd0, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 3'd1, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 3'd1, 1'b0);
    for (int i = 2; i < 6; i++) issue(32'h1234_5678, 32'h1234_5678, 3'(i), 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b1);
    issue(32'd1, 32'hFFFF_FFFF, 3'd0, 1'b1);
    issue(32'd5, 32'd9, 3'b110, 1'b0);
    issue(32'd9, 32'd9, 3'b111, 1'b1);
    drain();

    // Stall the consumer well past completion.
    or_mode = 2;
    issue(32'hDEAD_0000, 32'hDEAD_0001, 3'd5, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    or_mode = 0;
    drain();

    // Reset while the comparator is still walking chunks.
    issue(32'hCAFE_F00D, 32'hCAFE_F00D, 3'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_cmp_in_ready", in_ready, 1);
    chk("rst_cmp_out_valid", out_valid, 0);
    chk("rst_cmp_z", z, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 200; i++) begin
      or_mode = (i < 100) ? 0 : 1;
      ra = $urandom;
      case ($urandom % 4)
        0: rb = ra;
        1: rb = ra ^ (32'd1 << ($urandom % WIDTH));
        2: rb = $urandom;
        default: begin
          ra = $urandom % 4;
          rb = $urandom % 4;
        end
      endcase
      issue(ra, rb, 3'($urandom % 8), 1'($urandom % 2));
    end
    or_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
